// File: rtl/mips_fetch_if.sv
// rtl/mips_fetch_if.sv - instruction-memory request/response bus for the fetch stage
//
// Signals:
//   imem_req    fetch -> mem  request valid; imem_addr stable while high
//   imem_addr   fetch -> mem  byte address of the requested word (32)
//   imem_ready  mem -> fetch  request accepted this cycle
//   imem_rvalid mem -> fetch  read data valid
//   imem_rdata  mem -> fetch  instruction word (32)
// Modports: master = fetch stage, slave = instruction memory.

interface mips_fetch_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ready,
    input  imem_rvalid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ready,
    output imem_rvalid,
    output imem_rdata
  );
endinterface

// File: rtl/mips_fetch.sv
// rtl/mips_fetch.sv - MIPS instruction-fetch stage with single outstanding imem request
//
// Ports:
//   clk, reset   clock and synchronous active-high reset
//   imem         instruction-memory bus (mips_fetch_if.master)
//   instr        latched instruction word; op/funct are its [31:26]/[5:0] fields
//   pc, pcplus4  address of the current instruction and pc + 4
//   ivalid       instr is valid for decode; id_ready retires it
//   pcsrc, jump, pcbranch  next-pc feedback from the controller, used on retire only
//   retired      retired-instruction counter (wraps)
//   fault, fault_code  sticky fault: 01 misaligned target, 10 memory timeout

module mips_fetch #(
  parameter logic [31:0] RESET_PC = 32'h00000000,
  parameter int unsigned TIMEOUT  = 64
) (
  input  logic         clk,
  input  logic         reset,
  mips_fetch_if.master imem,
  output logic [31:0]  instr,
  output logic [5:0]   op,
  output logic [5:0]   funct,
  output logic [31:0]  pc,
  output logic [31:0]  pcplus4,
  output logic         ivalid,
  input  logic         id_ready,
  input  logic         pcsrc,
  input  logic         jump,
  input  logic [31:0]  pcbranch,
  output logic [31:0]  retired,
  output logic         fault,
  output logic [1:0]   fault_code
);

  typedef enum logic [1:0] {
    S_REQ   = 2'd0,
    S_WAIT  = 2'd1,
    S_VALID = 2'd2,
    S_HALT  = 2'd3
  } state_t;

  localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT - 1);

  state_t      state;
  logic [31:0] tcnt;
  logic [31:0] nextpc;
  logic [31:0] jtarget;
  logic        retire;

  assign pcplus4 = pc + 32'd4;
  assign op      = instr[31:26];
  assign funct   = instr[5:0];

  // Gated by reset so no request leaks out in the reset cycle even if the
  // FSM was sitting in REQ beforehand.
  assign imem.imem_req  = (state == S_REQ) && !reset;
  assign imem.imem_addr = pc;

  assign retire  = (state == S_VALID) && id_ready;
  assign jtarget = {pcplus4[31:28], instr[25:0], 2'b00};

  // Jump wins over a taken branch.
  always_comb begin
    nextpc = pcplus4;
    if (jump) begin
      nextpc = jtarget;
    end else if (pcsrc) begin
      nextpc = pcbranch;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_REQ;
      pc         <= RESET_PC;
      instr      <= '0;
      ivalid     <= 1'b0;
      retired    <= '0;
      fault      <= 1'b0;
      fault_code <= 2'b00;
      tcnt       <= '0;
    end else begin
      case (state)
        S_REQ: begin
          if (imem.imem_ready) begin
            state <= S_WAIT;
            tcnt  <= '0;
          end
        end

        S_WAIT: begin
          tcnt <= tcnt + 32'd1;
          // A response arriving in the last allowed cycle still counts.
          if (imem.imem_rvalid) begin
            instr  <= imem.imem_rdata;
            ivalid <= 1'b1;
            state  <= S_VALID;
          end else if (tcnt == TIMEOUT_LAST) begin
            fault      <= 1'b1;
            fault_code <= 2'b10;
            state      <= S_HALT;
          end
        end

        S_VALID: begin
          if (retire) begin
            // The instruction retires even when its successor is unusable.
            retired <= retired + 32'd1;
            ivalid  <= 1'b0;
            if (nextpc[1:0] != 2'b00) begin
              fault      <= 1'b1;
              fault_code <= 2'b01;
              state      <= S_HALT;
            end else begin
              pc    <= nextpc;
              state <= S_REQ;
            end
          end
        end

        S_HALT: begin
          // Frozen until reset.
        end

        default: begin
          state <= S_HALT;
        end
      endcase
    end
  end

endmodule

// File: doc/mips_fetch.md
Name: mips_fetch

Overview:
- Instruction-fetch stage directly upstream of the decode/controller.
- Holds the PC and issues one instruction-memory request at a time over a req/ready + rvalid handshake.
- Latches the returned word and presents instr/op/funct with a valid flag to decode.
- Computes the next PC from the pcsrc/jump/pcbranch feedback sampled when decode retires the instruction.
- Also provides a retired-instruction counter and sticky fault detection (misaligned target, memory timeout).

Parameters:
- RESET_PC, 32'h00000000: PC value loaded on reset; must be word-aligned.
- TIMEOUT, 64: maximum cycles spent in WAIT before a fault is raised; must be at least 1.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- imem_req  out  1  request valid; imem_addr is stable while this is high.
- imem_addr  out  32  byte address of the requested word; always equals pc.
- imem_ready  in  1  memory accepts the request this cycle.
- imem_rvalid  in  1  read data valid.
- imem_rdata  in  32  instruction word.
- instr  out  32  latched instruction.
- op  out  6  instr[31:26].
- funct  out  6  instr[5:0].
- pc  out  32  address of the current instruction.
- pcplus4  out  32  pc + 4, modulo 2^32.
- ivalid  out  1  instr is valid for decode.
- id_ready  in  1  decode consumes instr this cycle.
- pcsrc  in  1  branch taken (from controller).
- jump  in  1  jump (from controller).
- pcbranch  in  32  branch target.
- retired  out  32  count of retired instructions; wraps at 2^32.
- fault  out  1  sticky fault flag.
- fault_code  out  2  01 = misaligned target, 10 = memory timeout, 00 = none.

Behaviour:
- Reset values: pc=RESET_PC, state=REQ, instr=0, ivalid=0, retired=0, fault=0, fault_code=00, timeout counter=0. Reset wins over all other inputs in the same cycle, including mid-transaction.
- imem_req is 0 during any cycle in which reset is high.
- The memory side is also reset with this block; no stale responses are delivered after reset.
- FSM states: REQ, WAIT, VALID, HALT.
- REQ:
  - imem_req=1.
  - If imem_ready, go to WAIT and clear the timeout counter.
- WAIT:
  - imem_req=0; the counter increments each cycle.
  - If imem_rvalid: instr<=imem_rdata, ivalid<=1, go to VALID.
  - Otherwise, if the counter reaches TIMEOUT-1: fault<=1, fault_code<=10, go to HALT.
  - rvalid takes priority over timeout in the same cycle.
- VALID:
  - ivalid=1; instr, pc and pcplus4 are held stable until id_ready is high.
  - On id_ready (retire): compute nextpc, retired<=retired+1, ivalid<=0.
  - If nextpc[1:0]!=00: fault<=1, fault_code<=01, pc unchanged, go to HALT.
  - Otherwise pc<=nextpc and go to REQ.
- nextpc selection: jump has priority over pcsrc.
  - jump=1: nextpc = {pcplus4[31:28], instr[25:0], 2'b00}.
  - jump=0, pcsrc=1: nextpc = pcbranch.
  - Otherwise: nextpc = pcplus4.
- pcsrc, jump and pcbranch are ignored in every cycle that is not a retire cycle.
- HALT:
  - imem_req=0, ivalid=0; all state frozen until reset.
  - The retired increment on a faulting retire still counts.
- imem_rvalid is ignored outside WAIT.
- imem_ready is ignored outside REQ.
- Only one outstanding request exists at any time.
- Best-case timing: REQ accepted (cycle n), rvalid (n+1), ivalid high (n+2), retire (n+2), next REQ (n+3). That is one instruction per 3 cycles.
- pc wraps: pcplus4 of 32'hFFFFFFFC is 0.

Test Plan:
- Sequential fetch with zero-wait memory, id_ready=1, pcsrc=jump=0, RESET_PC=0 -> imem_addr 0,4,8,... issued every 3 cycles; instr matches memory; retired=3 after the third retire.
- Retire with pcsrc=1, pcbranch=0x40 -> next imem_addr=0x40. Same instruction retired with pcsrc=1 and jump=1 where instr=0x08000010 and pc=0x40 -> next imem_addr=0x40 (jump target 0x10<<2=0x40); change instr to 0x08000020 -> next imem_addr=0x80.
- Decode backpressure: id_ready low for 5 cycles while ivalid=1 -> instr/pc stable, no new imem_req, retired unchanged; pcsrc toggled during the stall has no effect.
- Memory delay: imem_ready low 4 cycles, then rvalid 10 cycles after acceptance -> imem_addr held throughout; single response latched. rvalid withheld for TIMEOUT cycles -> fault=1, fault_code=10, imem_req stays 0.
- Misaligned branch: retire with pcsrc=1, pcbranch=0x42 -> fault_code=01, pc unchanged, retired incremented, HALT.
- Reset asserted in WAIT and in HALT -> next cycle pc=RESET_PC, fault=0, ivalid=0, retired=0, imem_req=1.
